// File: rtl/mul_add_row_seq_pkg.sv
// Shared defaults and state type for the MonPro row-pass sequencer.
package mul_add_row_seq_pkg;

  // Word width of the datapath, equal to the mul_add width.
  localparam int DEF_DATA_WIDTH = 64;
  // Words per operand.
  localparam int DEF_NUM_WORDS  = 64;
  // Address width; wide enough to also reach t[NUM_WORDS].
  localparam int DEF_ADDR_W     = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_CARRY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mul_add_row_seq_if.sv
// Command and memory bus of the row-pass sequencer. The master side is the
// controller together with the b/t operand memories; the slave side is the
// sequencer itself.
interface mul_add_row_seq_if
  import mul_add_row_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_W     = DEF_ADDR_W
);

  logic                  start;
  logic                  acc_en;
  logic [DATA_WIDTH-1:0] a_word;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_WIDTH-1:0] b_rd_data;
  logic [DATA_WIDTH-1:0] t_rd_data;
  logic                  t_wr_en;
  logic [ADDR_W-1:0]     t_wr_addr;
  logic [DATA_WIDTH-1:0] t_wr_data;

  modport master (
    output start, acc_en, a_word, b_rd_data, t_rd_data,
    input  busy, done, rd_en, rd_addr, t_wr_en, t_wr_addr, t_wr_data
  );

  modport slave (
    input  start, acc_en, a_word, b_rd_data, t_rd_data,
    output busy, done, rd_en, rd_addr, t_wr_en, t_wr_addr, t_wr_data
  );

endinterface

// File: rtl/mul_add_row_seq_mul_add.sv
// Combinational word multiply-accumulate: {c, s} = x * y + z + last_c.
// The sum never exceeds 2^(2W)-1, so the double-width result cannot overflow.
module mul_add #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic [W-1:0] last_c,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [2*W-1:0] full_sum;

  assign full_sum = ({{W{1'b0}}, x} * {{W{1'b0}}, y})
                  + {{W{1'b0}}, z}
                  + {{W{1'b0}}, last_c};

  assign s = full_sum[W-1:0];
  assign c = full_sum[2*W-1:W];

endmodule

// File: rtl/mul_add_row_seq.sv
// Row-pass sequencer: t[0..N] <= t[0..N-1] + a * b[0..N-1], one word per
// cycle through a single mul_add, carrying a full word between iterations.
// DATA_WIDTH and ADDR_W must match the parameters of the connected bus.
module mul_add_row_seq
  import mul_add_row_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  mul_add_row_seq_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_J     = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] CARRY_ADDR = ADDR_W'(NUM_WORDS);

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     j_reg, j_next;
  logic [DATA_WIDTH-1:0] carry_reg, carry_next;
  logic [DATA_WIDTH-1:0] a_reg, a_next;
  logic                  acc_reg, acc_next;
  logic                  busy_reg, done_reg;

  logic [DATA_WIDTH-1:0] z_word;
  logic [DATA_WIDTH-1:0] s_word;
  logic [DATA_WIDTH-1:0] c_word;

  // Gate t with a mux so unknown read data cannot leak in when not accumulating.
  assign z_word = acc_reg ? bus.t_rd_data : '0;

  mul_add #(.W(DATA_WIDTH)) u_mul_add (
    .x      (a_reg),
    .y      (bus.b_rd_data),
    .z      (z_word),
    .last_c (carry_reg),
    .s      (s_word),
    .c      (c_word)
  );

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

  // State and operand registers; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      j_reg     <= '0;
      carry_reg <= '0;
      a_reg     <= '0;
      acc_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      j_reg     <= j_next;
      carry_reg <= carry_next;
      a_reg     <= a_next;
      acc_reg   <= acc_next;
      busy_reg  <= (state_next != ST_IDLE);
      done_reg  <= (state_next == ST_DONE);
    end
  end

  // Next-state logic and combinational memory strobes for the current word.
  always_comb begin
    state_next    = state_reg;
    j_next        = j_reg;
    carry_next    = carry_reg;
    a_next        = a_reg;
    acc_next      = acc_reg;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.t_wr_en   = 1'b0;
    bus.t_wr_addr = '0;
    bus.t_wr_data = '0;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          a_next     = bus.a_word;
          acc_next   = bus.acc_en;
          carry_next = '0;
          state_next = ST_PRIME;
        end
      end
      ST_PRIME: begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = '0;
        j_next      = '0;
        state_next  = ST_RUN;
      end
      ST_RUN: begin
        // Write word j while fetching j+1; the addresses never collide.
        bus.t_wr_en   = 1'b1;
        bus.t_wr_addr = j_reg;
        bus.t_wr_data = s_word;
        carry_next    = c_word;
        if (j_reg < LAST_J) begin
          bus.rd_en   = 1'b1;
          bus.rd_addr = j_reg + ADDR_W'(1);
          j_next      = j_reg + ADDR_W'(1);
        end else begin
          state_next  = ST_CARRY;
        end
      end
      ST_CARRY: begin
        bus.t_wr_en   = 1'b1;
        bus.t_wr_addr = CARRY_ADDR;
        bus.t_wr_data = carry_reg;
        state_next    = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_add_row_seq.sv
// Bench for the row-pass sequencer: two instances (4-word and 1-word rows)
// with behavioural b/t memories, compared against a big-integer row model.
module tb_mul_add_row_seq;
  import mul_add_row_seq_pkg::*;

  localparam int W    = 64;
  localparam int AW   = 7;
  localparam int NW0  = 4;
  localparam int NW1  = 1;
  localparam int BIGW = W * (NW0 + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mul_add_row_seq_if #(.DATA_WIDTH(W), .ADDR_W(AW)) if0 ();
  mul_add_row_seq_if #(.DATA_WIDTH(W), .ADDR_W(AW)) if1 ();

  mul_add_row_seq #(.DATA_WIDTH(W), .NUM_WORDS(NW0), .ADDR_W(AW)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  mul_add_row_seq #(.DATA_WIDTH(W), .NUM_WORDS(NW1), .ADDR_W(AW)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  // Memory contents, staging arrays and preload port.
  logic [W-1:0] b0 [0:7];
  logic [W-1:0] t0 [0:7];
  logic [W-1:0] b1 [0:7];
  logic [W-1:0] t1 [0:7];
  logic [W-1:0] sb [0:7];
  logic [W-1:0] st [0:7];
  logic         pl_we = 1'b0;
  logic         pl_sel = 1'b0;
  logic [2:0]   pl_idx = '0;
  logic [W-1:0] pl_b = '0;
  logic [W-1:0] pl_t = '0;
  int           wr_cnt0 = 0;
  int           wr_cnt1 = 0;

  // Synchronous-read memories with one read and one write port per instance.
  always @(posedge clk) begin
    if (if0.rd_en) begin
      if0.b_rd_data <= b0[if0.rd_addr[2:0]];
      if0.t_rd_data <= t0[if0.rd_addr[2:0]];
    end
    if (if1.rd_en) begin
      if1.b_rd_data <= b1[if1.rd_addr[2:0]];
      if1.t_rd_data <= t1[if1.rd_addr[2:0]];
    end
    if (if0.t_wr_en) begin
      t0[if0.t_wr_addr[2:0]] <= if0.t_wr_data;
      wr_cnt0 <= wr_cnt0 + 1;
    end
    if (if1.t_wr_en) begin
      t1[if1.t_wr_addr[2:0]] <= if1.t_wr_data;
      wr_cnt1 <= wr_cnt1 + 1;
    end
    if (pl_we) begin
      if (!pl_sel) begin
        b0[pl_idx] <= pl_b;
        t0[pl_idx] <= pl_t;
      end else begin
        b1[pl_idx] <= pl_b;
        t1[pl_idx] <= pl_t;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Copy staging arrays sb/st into memory sel, words 0..n-1.
  task automatic load_mem(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pl_we  = 1'b1;
      pl_sel = sel;
      pl_idx = 3'(i);
      pl_b   = sb[i];
      pl_t   = st[i];
      @(posedge clk);
      #1;
      pl_we  = 1'b0;
    end
  endtask

  task automatic rand_stage();
    for (int i = 0; i < 8; i++) begin
      sb[i] = {$urandom, $urandom};
      st[i] = {$urandom, $urandom};
    end
  endtask

  // One pass on dut0, called right after a negedge.
  // mode 0: drop start after acceptance; 1: keep start high throughout;
  // 2: drop start, raise it again during RUN and keep it high.
  task automatic run_pass0(input logic [W-1:0] a, input logic acc, input int mode);
    logic [BIGW-1:0] t_big;
    logic [BIGW-1:0] b_big;
    logic [BIGW-1:0] r_big;
    logic [W-1:0]    expw [0:NW0];
    int              edges;
    int              busy_cnt;
    int              c0;
    bit              done_seen;

    if0.start  = 1'b1;
    if0.a_word = a;
    if0.acc_en = acc;

    // Row result as one big integer: T + a * B.
    t_big = '0;
    b_big = '0;
    for (int j = 0; j < NW0; j++) begin
      t_big[W*j +: W] = acc ? t0[j] : '0;
      b_big[W*j +: W] = b0[j];
    end
    r_big = t_big + BIGW'(a) * b_big;
    for (int j = 0; j <= NW0; j++) expw[j] = r_big[W*j +: W];

    c0 = wr_cnt0;
    @(posedge clk);
    edges     = 1;
    busy_cnt  = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if0.a_word = {$urandom, $urandom};
        if0.acc_en = 1'($urandom);
        if (mode != 1) if0.start = 1'b0;
      end
      if (mode == 2 && k == 2) if0.start = 1'b1;
      if (if0.busy) busy_cnt++;
      if (if0.done) begin
        done_seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    chk("done_seen", 128'(done_seen), 128'(1));
    chk("done_latency", 128'(edges), 128'(NW0 + 3));
    chk("busy_cycles", 128'(busy_cnt), 128'(NW0 + 3));
    for (int j = 0; j <= NW0; j++) chk($sformatf("t[%0d]", j), 128'(t0[j]), 128'(expw[j]));
    @(negedge clk);
    chk("idle_after_done", 128'({if0.busy, if0.done}), 128'(0));
    chk("write_count", 128'(wr_cnt0 - c0), 128'(NW0 + 1));
    $display("pass dut0 a=%h acc=%0d mode=%0d latency=%0d t4=%h", a, acc, mode, edges, t0[NW0]);
  endtask

  initial begin
    int edges;
    int c1;
    bit done_seen;

    if0.start = 1'b0; if0.acc_en = 1'b0; if0.a_word = '0;
    if1.start = 1'b0; if1.acc_en = 1'b0; if1.a_word = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("reset_strobes0", 128'({if0.busy, if0.done, if0.rd_en, if0.t_wr_en}), 128'(0));
    chk("reset_addrs0", 128'({if0.rd_addr, if0.t_wr_addr, if0.t_wr_data}), 128'(0));
    chk("reset_strobes1", 128'({if1.busy, if1.done, if1.rd_en, if1.t_wr_en}), 128'(0));
    rst_n = 1'b1;

    // a=2, b={1,2,3,4}, garbage t, no accumulate.
    rand_stage();
    for (int i = 0; i < NW0; i++) sb[i] = W'(i + 1);
    load_mem(1'b0, NW0 + 1);
    @(negedge clk);
    run_pass0(64'd2, 1'b0, 0);
    chk("plain_t3", 128'(t0[3]), 128'(8));
    chk("plain_t4", 128'(t0[4]), 128'(0));

    // All-ones operands: full-width carry.
    for (int i = 0; i <= NW0; i++) begin
      sb[i] = '1;
      st[i] = '1;
    end
    load_mem(1'b0, NW0 + 1);
    @(negedge clk);
    run_pass0('1, 1'b1, 0);
    chk("ones_t0", 128'(t0[0]), 128'(0));
    chk("ones_t4", 128'(t0[4]), 128'(64'hFFFF_FFFF_FFFF_FFFF));

    // Carry propagating through zero words.
    for (int i = 0; i <= NW0; i++) begin
      sb[i] = '0;
      st[i] = '0;
    end
    sb[0] = '1;
    st[0] = 64'd5;
    st[NW0] = 64'hDEAD_BEEF;
    load_mem(1'b0, NW0 + 1);
    @(negedge clk);
    run_pass0(64'h1_0000_0000, 1'b1, 0);
    chk("zprop_t0", 128'(t0[0]), 128'(64'hFFFF_FFFF_0000_0005));
    chk("zprop_t1", 128'(t0[1]), 128'(64'hFFFF_FFFF));

    // start held high from acceptance through DONE; next pass after IDLE.
    rand_stage();
    load_mem(1'b0, NW0 + 1);
    @(negedge clk);
    run_pass0({$urandom, $urandom}, 1'b1, 1);
    run_pass0(if0.a_word, if0.acc_en, 0);

    // start raised during RUN and held through DONE.
    rand_stage();
    load_mem(1'b0, NW0 + 1);
    @(negedge clk);
    run_pass0({$urandom, $urandom}, 1'b1, 2);
    run_pass0(if0.a_word, if0.acc_en, 0);

    // Reset asserted in RUN at j=2.
    rand_stage();
    load_mem(1'b0, NW0 + 1);
    @(negedge clk);
    if0.start = 1'b1;
    if0.a_word = {$urandom, $urandom};
    if0.acc_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if0.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("j2_rd_addr", 128'(if0.rd_addr), 128'(3));
    chk("j2_wr_addr", 128'(if0.t_wr_addr), 128'(2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 128'({if0.busy, if0.done, if0.rd_en, if0.t_wr_en}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset in RUN j=2 applied");
    rand_stage();
    load_mem(1'b0, NW0 + 1);
    @(negedge clk);
    run_pass0({$urandom, $urandom}, 1'b1, 0);

    // Randomized passes.
    for (int r = 0; r < 6; r++) begin
      rand_stage();
      load_mem(1'b0, NW0 + 1);
      @(negedge clk);
      run_pass0({$urandom, $urandom}, 1'($urandom), 0);
    end

    // Single-word row: a=3, b={5}, t={7} accumulate -> t={22,0}.
    sb[0] = 64'd5;
    st[0] = 64'd7;
    st[1] = {$urandom, $urandom};
    load_mem(1'b1, 2);
    @(negedge clk);
    if1.start  = 1'b1;
    if1.a_word = 64'd3;
    if1.acc_en = 1'b1;
    c1 = wr_cnt1;
    @(posedge clk);
    edges = 1;
    done_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if1.start  = 1'b0;
        if1.a_word = 64'd99;
        if1.acc_en = 1'b0;
      end
      if (if1.done) begin
        done_seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    chk("n1_done_seen", 128'(done_seen), 128'(1));
    chk("n1_latency", 128'(edges), 128'(NW1 + 3));
    chk("n1_t0", 128'(t1[0]), 128'(22));
    chk("n1_t1", 128'(t1[1]), 128'(0));
    @(negedge clk);
    chk("n1_write_count", 128'(wr_cnt1 - c1), 128'(NW1 + 1));
    $display("pass dut1 a=3 acc=1 latency=%0d t0=%0d t1=%0d", edges, t1[0], t1[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
